// File: rtl/ibex_crc_unit_pkg.sv
// Shared ALU operator encodings plus CRC unit state, polynomials and operator decode helpers.
package ibex_crc_unit_pkg;

  typedef enum logic [5:0] {
    ALU_ADD      = 6'd0,
    ALU_SUB      = 6'd1,
    ALU_XOR      = 6'd2,
    ALU_OR       = 6'd3,
    ALU_AND      = 6'd4,
    ALU_CRC32_B  = 6'd48,
    ALU_CRC32C_B = 6'd49,
    ALU_CRC32_H  = 6'd50,
    ALU_CRC32C_H = 6'd51,
    ALU_CRC32_W  = 6'd52,
    ALU_CRC32C_W = 6'd53
  } alu_op_e;

  typedef enum logic [1:0] {
    CRC_IDLE,
    CRC_BUSY,
    CRC_DONE
  } crc_state_e;

  parameter logic [31:0] CRC32_POLY  = 32'hEDB88320;
  parameter logic [31:0] CRC32C_POLY = 32'h82F63B78;

  function automatic logic crc_is_op(logic [5:0] op);
    return (op == ALU_CRC32_B) || (op == ALU_CRC32C_B) ||
           (op == ALU_CRC32_H) || (op == ALU_CRC32C_H) ||
           (op == ALU_CRC32_W) || (op == ALU_CRC32C_W);
  endfunction

  // Anything that is not a CRC32C op falls back to the plain CRC32 polynomial.
  function automatic logic [31:0] crc_poly(logic [5:0] op);
    if ((op == ALU_CRC32C_B) || (op == ALU_CRC32C_H) || (op == ALU_CRC32C_W))
      return CRC32C_POLY;
    return CRC32_POLY;
  endfunction

  function automatic logic [6:0] crc_nbits(logic [5:0] op);
    if ((op == ALU_CRC32_B) || (op == ALU_CRC32C_B)) return 7'd8;
    if ((op == ALU_CRC32_H) || (op == ALU_CRC32C_H)) return 7'd16;
    return 7'd32;
  endfunction

endpackage

// File: rtl/ibex_crc_unit_step.sv
// Combinational reflected-CRC kernel: applies BitsPerCycle single-bit steps to x.
module ibex_crc_step #(
  parameter int unsigned BitsPerCycle = 4
) (
  input  logic [31:0] x_i,
  input  logic [31:0] poly_i,
  output logic [31:0] x_o
);

  always_comb begin
    logic [31:0] x;
    x = x_i;
    for (int i = 0; i < BitsPerCycle; i++) begin
      x = (x >> 1) ^ (poly_i & {32{x[0]}});
    end
    x_o = x;
  end

endmodule

// File: rtl/ibex_crc_unit.sv
// Multi-cycle bit-serial CRC32/CRC32C unit for crc32[c].{b,h,w}.
// Optional feature macro: IBEX_CRC_ILLEGAL_OP_EN (flag non-CRC operators instead of running CRC32_W).
module ibex_crc_unit
  import ibex_crc_unit_pkg::*;
#(
  parameter int unsigned BitsPerCycle = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic        kill_i,
  input  logic [5:0]  operator_i,
  input  logic [31:0] operand_i,
  output logic        ready_o,
  output logic        valid_o,
  output logic [31:0] result_o,
  output logic        illegal_op_o
);

  localparam int unsigned Shift = $clog2(BitsPerCycle);

  if (!(BitsPerCycle == 1 || BitsPerCycle == 2 || BitsPerCycle == 4 || BitsPerCycle == 8))
  begin : g_bad_bits_per_cycle
    $error("ibex_crc_unit: BitsPerCycle must be 1, 2, 4 or 8");
  end

  crc_state_e  state_q, state_d;
  logic [31:0] x_q, x_d, poly_q, poly_d, x_step;
  logic [5:0]  cnt_q, cnt_d;
  logic        accept, op_legal;

  assign accept = start_i & ready_o & ~kill_i;

`ifdef IBEX_CRC_ILLEGAL_OP_EN
  logic illegal_q;
  assign op_legal = crc_is_op(operator_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)     illegal_q <= 1'b0;
    else if (accept) illegal_q <= ~op_legal;
  end

  assign illegal_op_o = valid_o & illegal_q;
`else
  assign op_legal     = 1'b1;
  assign illegal_op_o = 1'b0;
`endif

  ibex_crc_step #(.BitsPerCycle(BitsPerCycle)) u_step (
    .x_i   (x_q),
    .poly_i(poly_q),
    .x_o   (x_step)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= CRC_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      CRC_IDLE: if (accept) state_d = op_legal ? CRC_BUSY : CRC_DONE;
      CRC_BUSY: if (cnt_q == 6'd0) state_d = CRC_DONE;
      CRC_DONE: state_d = accept ? (op_legal ? CRC_BUSY : CRC_DONE) : CRC_IDLE;
      default:  state_d = CRC_IDLE;
    endcase
    if (kill_i) state_d = CRC_IDLE;
  end

  always_comb begin
    ready_o = (state_q == CRC_IDLE) || (state_q == CRC_DONE);
    valid_o = (state_q == CRC_DONE) && !kill_i;
  end

  // x is frozen on kill so result_o keeps the last value until the next accept.
  always_comb begin
    x_d    = x_q;
    poly_d = poly_q;
    cnt_d  = cnt_q;
    if (accept) begin
      x_d    = op_legal ? operand_i : 32'h0;
      poly_d = crc_poly(operator_i);
      cnt_d  = 6'((crc_nbits(operator_i) >> Shift) - 7'd1);
    end else if ((state_q == CRC_BUSY) && !kill_i) begin
      x_d   = x_step;
      cnt_d = cnt_q - 6'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      x_q    <= 32'h0;
      poly_q <= 32'h0;
      cnt_q  <= 6'd0;
    end else begin
      x_q    <= x_d;
      poly_q <= poly_d;
      cnt_q  <= cnt_d;
    end
  end

  assign result_o = x_q;

endmodule

// File: tb/tb_ibex_crc_unit.sv
// Randomized self-checking bench for ibex_crc_unit against a bit-loop CRC reference model.
module tb_ibex_crc_unit;
  import ibex_crc_unit_pkg::*;

  localparam int BPC = 4;

  logic        clk, rst_ni, start_i, kill_i;
  logic [5:0]  operator_i;
  logic [31:0] operand_i, result_o;
  logic        ready_o, valid_o, illegal_op_o;

  int n_chk = 0;
  int n_err = 0;

  ibex_crc_unit #(.BitsPerCycle(BPC)) u_dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .start_i     (start_i),
    .kill_i      (kill_i),
    .operator_i  (operator_i),
    .operand_i   (operand_i),
    .ready_o     (ready_o),
    .valid_o     (valid_o),
    .result_o    (result_o),
    .illegal_op_o(illegal_op_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

`ifdef IBEX_CRC_ILLEGAL_OP_EN
  localparam bit ILL_EN = 1'b1;
`else
  localparam bit ILL_EN = 1'b0;
`endif

  // Reference: explicit reflected CRC, one bit at a time.
  function automatic logic [31:0] ref_steps(logic [31:0] x, logic [31:0] poly, int n);
    for (int i = 0; i < n; i++) begin
      if (x[0]) x = (x >> 1) ^ poly;
      else      x = x >> 1;
    end
    return x;
  endfunction

  function automatic void ref_cfg(input logic [5:0] op, output logic [31:0] poly,
                                  output int nbits, output bit legal);
    legal = 1'b1;
    poly  = 32'hEDB88320;
    nbits = 32;
    case (op)
      ALU_CRC32_B:  nbits = 8;
      ALU_CRC32C_B: begin nbits = 8;  poly = 32'h82F63B78; end
      ALU_CRC32_H:  nbits = 16;
      ALU_CRC32C_H: begin nbits = 16; poly = 32'h82F63B78; end
      ALU_CRC32_W:  nbits = 32;
      ALU_CRC32C_W: poly = 32'h82F63B78;
      default:      legal = 1'b0;
    endcase
  endfunction

  function automatic void ref_op(input logic [5:0] op, input logic [31:0] d,
                                 output int lat, output logic [31:0] res, output logic ill);
    logic [31:0] poly; int nbits; bit legal;
    ref_cfg(op, poly, nbits, legal);
    if (!legal && ILL_EN) begin
      lat = 1; res = 32'h0; ill = 1'b1;
    end else begin
      lat = nbits / BPC + 1; res = ref_steps(d, poly, nbits); ill = 1'b0;
    end
  endfunction

  // Present a start for one cycle; returns just after the accept edge (cycle 1).
  task automatic issue(input logic [5:0] op, input logic [31:0] d);
    start_i = 1'b1; operator_i = op; operand_i = d;
    @(posedge clk); #1;
    start_i = 1'b0; operator_i = 6'($urandom_range(0, 63)); operand_i = $urandom;
  endtask

  // Starting in cycle 1, look for valid_o; lat = -1 if it never comes.
  task automatic wait_valid(output int lat, output logic [31:0] res, output logic ill);
    lat = -1; res = '0; ill = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (valid_o) begin lat = c; res = result_o; ill = illegal_op_o; break; end
      @(posedge clk); #1;
    end
  endtask

  task automatic run_check(input string tag, input logic [5:0] op, input logic [31:0] d);
    int el, al; logic [31:0] er, ar; logic ei, ai;
    ref_op(op, d, el, er, ei);
    issue(op, d);
    wait_valid(al, ar, ai);
    chk({tag, "_lat"}, 32'(al), 32'(el));
    chk({tag, "_res"}, ar, er);
    chk({tag, "_ill"}, 32'(ai), 32'(ei));
    if (al > 0) begin @(posedge clk); #1; end
  endtask

  localparam logic [5:0] CRC_OPS [6] = '{ALU_CRC32_B, ALU_CRC32C_B, ALU_CRC32_H,
                                         ALU_CRC32C_H, ALU_CRC32_W, ALU_CRC32C_W};

  initial begin
    int el, al; logic [31:0] er, ar, d; logic ei, ai;
    logic [5:0] op;
    rst_ni = 1'b0; start_i = 1'b0; kill_i = 1'b0; operator_i = '0; operand_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(ready_o), 32'd1);
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_result", result_o, 32'h0);
    chk("rst_illegal", 32'(illegal_op_o), 32'd0);
    rst_ni = 1'b1;
    @(posedge clk); #1;

    // Directed vectors
    run_check("crc32_b", ALU_CRC32_B, 32'h00000080);
    run_check("crc32c_b", ALU_CRC32C_B, 32'h00000080);
    run_check("crc32_h", ALU_CRC32_H, 32'h00008000);
    run_check("crc32_w_top", ALU_CRC32_W, 32'h80000000);
    run_check("crc32_w_zero", ALU_CRC32_W, 32'h0);
    run_check("illegal_add", ALU_ADD, 32'h12345678);

    // Random ops with idle gaps
    for (int i = 0; i < 24; i++) begin
      op = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(0, 4)) : CRC_OPS[$urandom_range(0, 5)];
      run_check("rand", op, $urandom);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    // Back-to-back: second start presented in the DONE cycle of the first
    d = $urandom;
    ref_op(ALU_CRC32C_H, d, el, er, ei);
    issue(ALU_CRC32C_H, d);
    for (int c = 1; c < el; c++) begin @(posedge clk); #1; end
    d = $urandom;
    start_i = 1'b1; operator_i = ALU_CRC32_B; operand_i = d;
    @(negedge clk);
    chk("b2b_first_valid", 32'(valid_o), 32'd1);
    chk("b2b_first_res", result_o, er);
    chk("b2b_ready_in_done", 32'(ready_o), 32'd1);
    @(posedge clk); #1;
    start_i = 1'b0; operator_i = 6'($urandom_range(0, 63)); operand_i = $urandom;
    ref_op(ALU_CRC32_B, d, el, er, ei);
    wait_valid(al, ar, ai);
    chk("b2b_second_lat", 32'(al), 32'(el));
    chk("b2b_second_res", ar, er);
    if (al > 0) begin @(posedge clk); #1; end

    // Kill in BUSY cycle 2
    d = $urandom;
    issue(ALU_CRC32_W, d);
    @(posedge clk); #1;
    kill_i = 1'b1;
    @(negedge clk);
    chk("kill_valid", 32'(valid_o), 32'd0);
    @(posedge clk); #1;
    kill_i = 1'b0;
    @(negedge clk);
    chk("kill_ready_next", 32'(ready_o), 32'd1);
    er = ref_steps(d, 32'hEDB88320, BPC);
    chk("kill_result_held", result_o, er);
    wait_valid(al, ar, ai);
    chk("kill_no_valid", 32'(al), 32'hFFFFFFFF);

    // Kill with start in IDLE: not accepted
    start_i = 1'b1; kill_i = 1'b1; operator_i = ALU_CRC32_B; operand_i = $urandom;
    @(posedge clk); #1;
    start_i = 1'b0; kill_i = 1'b0;
    @(negedge clk);
    chk("killstart_ready", 32'(ready_o), 32'd1);
    chk("killstart_result", result_o, er);
    @(posedge clk); #1;
    wait_valid(al, ar, ai);
    chk("killstart_no_valid", 32'(al), 32'hFFFFFFFF);

    // Reset mid-BUSY
    issue(ALU_CRC32_W, $urandom);
    @(posedge clk); #1;
    rst_ni = 1'b0;
    #1;
    chk("midrst_ready", 32'(ready_o), 32'd1);
    chk("midrst_valid", 32'(valid_o), 32'd0);
    chk("midrst_result", result_o, 32'h0);
    chk("midrst_illegal", 32'(illegal_op_o), 32'd0);
    @(negedge clk);
    rst_ni = 1'b1;
    @(posedge clk); #1;
    wait_valid(al, ar, ai);
    chk("midrst_no_valid", 32'(al), 32'hFFFFFFFF);
    run_check("post_rst", ALU_CRC32C_W, $urandom);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/ibex_crc_unit.md
# ibex_crc_unit

Multi-cycle CRC32/CRC32C execution unit for the RV32B `crc32[c].{b,h,w}` instructions. It sits directly downstream of the decoder/ALU operator select. It is started by the ID/EX stage when `alu_operator` is one of the six `ALU_CRC32*` encodings, and it returns the result to the EX result mux. Bit-serial iteration, processing a configurable number of bits per cycle, keeps area small next to the single-cycle ALU.

## Interface
- `BitsPerCycle`, default 4: bits processed per BUSY cycle. Legal values are 1, 2, 4, 8; an elaboration-time assertion rejects anything else.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `start_i`  in  1  request a CRC operation; accepted only when `ready_o`=1.
- `kill_i`  in  1  flush the pipeline; abort any operation.
- `operator_i`  in  6  `alu_op_e` operator; sampled on accept.
- `operand_i`  in  32  rs1 value; sampled on accept.
- `ready_o`  out  1  unit can accept `start_i`.
- `valid_o`  out  1  one-cycle pulse; `result_o` holds the final CRC.
- `result_o`  out  32  CRC result.
- `illegal_op_o`  out  1  accepted operator was not a CRC op (see Configuration).

## Operation
- Polynomials are in reflected form: CRC32 uses 32'hEDB88320; CRC32C uses 32'h82F63B78.
- Width `nbits`: B=8, H=16, W=32.
- One bit step is `x = (x >> 1) ^ (poly & {32{x[0]}})`.
- Each BUSY cycle applies `BitsPerCycle` bit steps combinationally.
- Step count per operation: `N = nbits / BitsPerCycle`. The step counter is 6 bits wide and counts down from N-1 to 0.
- Results are full 32-bit x, with no masking or zero-extension.
- FSM states and transitions:
  - IDLE: on accept, load x, poly and N-1, then go to BUSY.
  - BUSY: step each cycle; when counter = 0, go to DONE.
  - DONE: `valid_o`=1 for one cycle. Go to BUSY if a new start is accepted, otherwise go to IDLE.
- `ready_o` = 1 in IDLE and DONE, which gives back-to-back issue.
- `kill_i`:
  - In any state, the next state is IDLE and `valid_o` is forced to 0 in the kill cycle.
  - `kill_i` together with `start_i` means the start is not accepted.
- `result_o` holds the last x until the next accept, including after a kill.

## Timing
- Reset values: state=IDLE, `ready_o`=1, `valid_o`=0, `result_o`=0, `illegal_op_o`=0.
- Latency is measured from the accept cycle (cycle 0).
  - BUSY occupies cycles 1..N.
  - `valid_o` is high in cycle N+1.
  - Total latency is N+1 cycles.
- With BitsPerCycle=4, latency is B=3, H=5, W=9 cycles.
- With BitsPerCycle=1, latency is B=9, H=17, W=33 cycles.
- Reset asserted mid-operation returns all state to reset values immediately, with no valid pulse.
- `operator_i` and `operand_i` may change after the accept cycle.

## Configuration
- Macro: `IBEX_CRC_ILLEGAL_OP_EN`.
- Defined:
  - A non-CRC `operator_i` at accept skips BUSY and goes directly to DONE (latency 1).
  - In DONE, `valid_o`=1, `illegal_op_o`=1 and `result_o`=0.
- Undefined:
  - `illegal_op_o` is tied to 0.
  - Any non-CRC operator decodes as CRC32_W (`operator_i[0]`-independent default).

## Structure
- Shared package additions, placed next to `alu_op_e`:
  - `crc_state_e` {CRC_IDLE, CRC_BUSY, CRC_DONE}.
  - Parameters `CRC32_POLY` and `CRC32C_POLY`.
- Sub-module `ibex_crc_step`: combinational function that applies `BitsPerCycle` bit steps (x, poly → x'). It is instantiated once and is reusable by a future single-cycle variant.

## Test plan
- CRC32_B, operand 32'h00000080, BitsPerCycle=4 → `valid_o` in cycle 3, result 32'hEDB88320.
- CRC32C_B, same operand → result 32'h82F63B78. CRC32_H with 32'h00008000 → 32'hEDB88320 in cycle 5.
- CRC32_W, operand 32'h80000000, BitsPerCycle=1 → 32'hEDB88320 in cycle 33. Operand 0 → result 0.
- Back-to-back: new start in the DONE cycle → second `valid_o` exactly N+1 cycles later, with no idle cycle between.
- Kill cases:
  - `kill_i` in BUSY cycle 2 → no `valid_o`, `ready_o`=1 next cycle.
  - `kill_i`+`start_i` in IDLE → no accept.
  - `rst_ni` low mid-BUSY → all outputs at reset values.
- Illegal operator ALU_ADD:
  - With `IBEX_CRC_ILLEGAL_OP_EN` → `valid_o`+`illegal_op_o` in cycle 1.
  - Without it → treated as CRC32_W.
